// File: rtl/store_buffer.sv
// In-order store FIFO in front of the data_mem port.
// Loads own the port; queued stores forward to matching loads.
module store_buffer #(
  parameter int WL    = 32,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     st_valid,
  input  logic [WL-1:0]            st_addr,
  input  logic [WL-1:0]            st_data,
  output logic                     st_ready,
  input  logic                     ld_valid,
  input  logic [WL-1:0]            ld_addr,
  output logic [WL-1:0]            ld_data,
  output logic                     ld_hit,
  output logic                     mem_write_EN,
  output logic [WL-1:0]            mem_addr,
  output logic [WL-1:0]            mem_writeData,
  input  logic [WL-1:0]            mem_readData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WL-1:0]    addr_q [DEPTH];
  logic [WL-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt_q;

  logic             push;
  logic             drain;
  logic             fwd_hit;
  logic [WL-1:0]    fwd_data;
  logic [AW-1:0]    idx;

  assign empty    = (cnt_q == '0);
  assign st_ready = (cnt_q != FULL);
  assign count    = cnt_q;

  assign push  = st_valid & st_ready;
  assign drain = ~empty & ~ld_valid;

  assign mem_write_EN  = drain;
  assign mem_addr      = drain ? addr_q[rd_ptr] : ld_addr;
  assign mem_writeData = data_q[rd_ptr];

  // Walk oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = DEPTH; i >= 1; i--) begin
      idx = wr_ptr - AW'(i);
      if (vld_q[idx] && addr_q[idx] == ld_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  assign ld_hit  = fwd_hit;
  assign ld_data = fwd_hit ? fwd_data : mem_readData;

  always_ff @(posedge CLK) begin
    if (push) begin
      addr_q[wr_ptr] <= st_addr;
      data_q[wr_ptr] <= st_data;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        vld_q[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (drain) begin
        vld_q[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      unique case ({push, drain})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule
